// File: rtl/wb_mem_bist_if.sv
// rtl/wb_mem_bist_if.sv - Wishbone classic bus bundle (wshb_if) carrying clock and reset
interface wshb_if (
    input logic clk,
    input logic rst
);
    logic        cyc;
    logic        stb;
    logic        we;
    logic [31:0] adr;
    logic [3:0]  sel;
    logic [31:0] dat_ms;
    logic [2:0]  cti;
    logic [1:0]  bte;
    logic        ack;
    logic        err;
    logic [31:0] dat_sm;

    modport master (
        input  clk, rst, ack, err, dat_sm,
        output cyc, stb, we, adr, sel, dat_ms, cti, bte
    );

    modport slave (
        input  clk, rst, cyc, stb, we, adr, sel, dat_ms, cti, bte,
        output ack, err, dat_sm
    );
endinterface

// File: rtl/wb_mem_bist.sv
// rtl/wb_mem_bist.sv - Wishbone master memory BIST: write a seeded pattern, read back and compare
module wb_mem_bist #(
    parameter int          mem_adr_width = 11,
    parameter logic [31:0] BASE_ADR      = 32'h0000_0000,
    parameter int          TIMEOUT       = 255
) (
    wshb_if.master              wb_m,
    input  logic                start,
    input  logic [mem_adr_width:0] len,
    input  logic [31:0]         seed,
    output logic                busy,
    output logic                done,
    output logic                pass,
    output logic [15:0]         err_count,
    output logic [31:0]         first_fail_adr,
    output logic                timeout,
    output logic                bus_err
);
    localparam int TW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [mem_adr_width:0] ONE  = 1;
    localparam logic [mem_adr_width:0] ZERO = 0;

    typedef enum logic [1:0] {IDLE, WRITE, READ, DONE} state_t;

    state_t                 r_state;
    logic [mem_adr_width:0] r_len;
    logic [mem_adr_width:0] r_idx;
    logic [31:0]            r_seed;
    logic [TW-1:0]          r_timer;
    logic                   r_cyc;
    logic                   r_we;
    logic [31:0]            r_adr;
    logic [31:0]            r_dat;
    logic [3:0]             r_sel;
    logic                   r_busy;
    logic                   r_done;
    logic                   r_pass;
    logic [15:0]            r_err_count;
    logic [31:0]            r_first_fail_adr;
    logic                   r_timeout;
    logic                   r_bus_err;

    logic [15:0] w_i16;
    logic [31:0] w_pattern;
    logic [31:0] w_adr;
    logic        w_last;
    logic        w_mismatch;

    assign w_i16      = 16'(r_idx);
    assign w_pattern  = {w_i16, ~w_i16} ^ r_seed;
    assign w_adr      = BASE_ADR + (32'(r_idx) << 2);
    assign w_last     = (r_idx == r_len - ONE);
    assign w_mismatch = (wb_m.dat_sm != w_pattern);

    assign wb_m.cyc    = r_cyc;
    assign wb_m.stb    = r_cyc;
    assign wb_m.we     = r_we;
    assign wb_m.adr    = r_adr;
    assign wb_m.sel    = r_sel;
    assign wb_m.dat_ms = r_dat;
    assign wb_m.cti    = 3'b000;
    assign wb_m.bte    = 2'b00;

    assign busy           = r_busy;
    assign done           = r_done;
    assign pass           = r_pass;
    assign err_count      = r_err_count;
    assign first_fail_adr = r_first_fail_adr;
    assign timeout        = r_timeout;
    assign bus_err        = r_bus_err;

    always_ff @(posedge wb_m.clk or posedge wb_m.rst) begin
        if (wb_m.rst) begin
            r_state          <= IDLE;
            r_len            <= '0;
            r_idx            <= '0;
            r_seed           <= '0;
            r_timer          <= '0;
            r_cyc            <= 1'b0;
            r_we             <= 1'b0;
            r_adr            <= '0;
            r_dat            <= '0;
            r_sel            <= '0;
            r_busy           <= 1'b0;
            r_done           <= 1'b0;
            r_pass           <= 1'b0;
            r_err_count      <= '0;
            r_first_fail_adr <= '0;
            r_timeout        <= 1'b0;
            r_bus_err        <= 1'b0;
        end else begin
            case (r_state)
                IDLE, DONE: begin
                    if (start) begin
                        r_len            <= len;
                        r_seed           <= seed;
                        r_idx            <= '0;
                        r_err_count      <= '0;
                        r_first_fail_adr <= '0;
                        r_timeout        <= 1'b0;
                        r_bus_err        <= 1'b0;
                        if (len == ZERO) begin
                            r_state <= DONE;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                            r_pass  <= 1'b1;
                        end else begin
                            r_state <= WRITE;
                            r_busy  <= 1'b1;
                            r_done  <= 1'b0;
                            r_pass  <= 1'b0;
                        end
                    end
                end
                WRITE, READ: begin
                    // bus idle here is the mandatory one-cycle gap between words
                    if (!r_cyc) begin
                        r_cyc   <= 1'b1;
                        r_adr   <= w_adr;
                        r_we    <= (r_state == WRITE);
                        r_sel   <= 4'hF;
                        r_timer <= '0;
                        if (r_state == WRITE) begin
                            r_dat <= w_pattern;
                        end
                    end else if (wb_m.err) begin
                        r_cyc     <= 1'b0;
                        r_bus_err <= 1'b1;
                        r_state   <= DONE;
                        r_busy    <= 1'b0;
                        r_done    <= 1'b1;
                        r_pass    <= 1'b0;
                    end else if (wb_m.ack) begin
                        r_cyc <= 1'b0;
                        if (r_state == READ && w_mismatch) begin
                            if (r_err_count == 16'h0000) begin
                                r_first_fail_adr <= r_adr;
                            end
                            if (r_err_count != 16'hFFFF) begin
                                r_err_count <= r_err_count + 16'h0001;
                            end
                        end
                        if (!w_last) begin
                            r_idx <= r_idx + ONE;
                        end else if (r_state == WRITE) begin
                            r_state <= READ;
                            r_idx   <= '0;
                        end else begin
                            r_state <= DONE;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                            r_pass  <= (r_err_count == 16'h0000) && !w_mismatch
                                       && !r_timeout && !r_bus_err;
                        end
                    end else if (r_timer == TW'(TIMEOUT - 1)) begin
                        r_cyc     <= 1'b0;
                        r_timeout <= 1'b1;
                        r_state   <= DONE;
                        r_busy    <= 1'b0;
                        r_done    <= 1'b1;
                        r_pass    <= 1'b0;
                    end else begin
                        r_timer <= r_timer + 1'b1;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_wb_mem_bist.sv
// tb/tb_wb_mem_bist.sv - scoreboard bench for wb_mem_bist with a mode-switchable Wishbone slave
module tb_wb_mem_bist;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [11:0] len = '0;
    logic [31:0] seed = '0;
    logic        busy, done, pass, timeout, bus_err;
    logic [15:0] err_count;
    logic [31:0] first_fail_adr;

    typedef struct packed {
        logic        p;
        logic [15:0] ec;
        logic [31:0] ffa;
        logic        to;
        logic        be;
    } status_t;

    logic [73:0] bus_q[$];
    status_t     st_q[$];
    int          n_cmp = 0;
    int          n_fail = 0;
    int          mode = 0;      // 0 normal, 1 flip bit0 on read of 0x8, 2 never ack, 3 err on write to 0x4
    logic [31:0] mem [0:2047];

    always #5 clk = ~clk;

    wshb_if wb (.clk(clk), .rst(rst));

    wb_mem_bist #(.mem_adr_width(11), .BASE_ADR(32'h0), .TIMEOUT(255)) dut (
        .wb_m(wb), .start(start), .len(len), .seed(seed),
        .busy(busy), .done(done), .pass(pass), .err_count(err_count),
        .first_fail_adr(first_fail_adr), .timeout(timeout), .bus_err(bus_err)
    );

    always @(posedge clk) begin
        if (rst) begin
            wb.ack    <= 1'b0;
            wb.err    <= 1'b0;
            wb.dat_sm <= '0;
        end else begin
            wb.ack <= 1'b0;
            wb.err <= 1'b0;
            if (wb.cyc && wb.stb && !wb.ack && !wb.err && mode != 2) begin
                if (mode == 3 && wb.we && wb.adr == 32'h4) begin
                    wb.err <= 1'b1;
                end else begin
                    wb.ack <= 1'b1;
                    if (wb.we) mem[wb.adr[12:2]] <= wb.dat_ms;
                    else wb.dat_sm <= mem[wb.adr[12:2]] ^ ((mode == 1 && wb.adr == 32'h8) ? 32'h1 : 32'h0);
                end
            end
        end
    end

    task automatic check(input string nm, input logic [73:0] act, input logic [73:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic check_status(input status_t e);
        check("st_pass", 74'(pass), 74'(e.p));
        check("st_err_count", 74'(err_count), 74'(e.ec));
        check("st_first_fail_adr", 74'(first_fail_adr), 74'(e.ffa));
        check("st_timeout", 74'(timeout), 74'(e.to));
        check("st_bus_err", 74'(bus_err), 74'(e.be));
    endtask

    logic        prev_stb = 1'b0;
    logic        prev_done = 1'b0;
    int          stb_len = 0;
    int          last_stb_len = 0;
    int          n_ack = 0;
    logic [31:0] cur_adr = '0;
    logic [31:0] last_adr = '0;

    // monitor: pops expected transactions on each stb rise, expected status on each done rise
    always @(negedge clk) begin
        if (wb.stb && !prev_stb) begin
            cur_adr  <= wb.adr;
            last_adr <= wb.adr;
            stb_len  <= 1;
            if (bus_q.size() == 0) check("unexpected_txn", 74'(1), 74'(0));
            else check("txn", {wb.we, wb.sel, wb.cti, wb.bte, wb.adr, wb.we ? wb.dat_ms : 32'h0},
                       bus_q.pop_front());
        end else if (wb.stb) begin
            stb_len <= stb_len + 1;
        end
        if (!wb.stb && prev_stb) last_stb_len <= stb_len;
        if (wb.stb && prev_stb && (wb.ack || wb.err)) begin
            if (wb.ack) n_ack <= n_ack + 1;
            check("hold_adr", 74'(wb.adr), 74'(cur_adr));
        end
        if (done && !prev_done) begin
            if (st_q.size() == 0) check("unexpected_done", 74'(1), 74'(0));
            else check_status(st_q.pop_front());
        end
        prev_stb  <= wb.stb;
        prev_done <= done;
    end

    task automatic push_txn(input logic we, input logic [31:0] adr, input logic [31:0] dat);
        bus_q.push_back({we, 4'hF, 3'b000, 2'b00, adr, we ? dat : 32'h0});
    endtask

    task automatic push_run(input logic [31:0] d0, input logic [31:0] d1,
                            input logic [31:0] d2, input logic [31:0] d3);
        push_txn(1'b1, 32'h0, d0);
        push_txn(1'b1, 32'h4, d1);
        push_txn(1'b1, 32'h8, d2);
        push_txn(1'b1, 32'hC, d3);
        for (int i = 0; i < 4; i++) push_txn(1'b0, 32'(i * 4), 32'h0);
    endtask

    task automatic pulse_start(input logic [11:0] l, input logic [31:0] s);
        @(negedge clk);
        len   = l;
        seed  = s;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input int maxc);
        int c;
        c = 0;
        while (!done && c < maxc) begin
            @(negedge clk);
            c++;
        end
        check("done_reached", 74'(done), 74'(1));
        repeat (2) @(negedge clk);
        check("txn_queue_drained", 74'(bus_q.size()), 74'(0));
        check("status_queue_drained", 74'(st_q.size()), 74'(0));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int a0;
        int c;
        repeat (3) @(negedge clk);
        check("rst_cyc", 74'(wb.cyc), 74'(0));
        check("rst_stb", 74'(wb.stb), 74'(0));
        check("rst_adr_dat", {10'h0, wb.adr, wb.dat_ms}, 74'(0));
        check("rst_flags", 74'({busy, done, pass, timeout, bus_err}), 74'(0));
        check("rst_counters", 74'({err_count, first_fail_adr}), 74'(0));
        rst = 1'b0;

        // len=0: immediate done with pass, no bus activity
        st_q.push_back('{p: 1'b1, ec: 16'h0, ffa: 32'h0, to: 1'b0, be: 1'b0});
        pulse_start(12'd0, 32'h1234_5678);
        check("len0_done_pass", 74'({done, pass, busy}), 74'(3'b110));
        repeat (5) @(negedge clk);
        check("len0_status_popped", 74'(st_q.size()), 74'(0));

        // len=4 seed=0, with ignored start pulses while busy
        mode = 0;
        push_run(32'h0000FFFF, 32'h0001FFFE, 32'h0002FFFD, 32'h0003FFFC);
        st_q.push_back('{p: 1'b1, ec: 16'h0, ffa: 32'h0, to: 1'b0, be: 1'b0});
        pulse_start(12'd4, 32'h0);
        check("busy_after_start", 74'(busy), 74'(1));
        repeat (4) @(negedge clk);
        pulse_start(12'd2, 32'hFFFF_FFFF);
        repeat (7) @(negedge clk);
        pulse_start(12'd9, 32'h0F0F_0F0F);
        wait_done(200);

        // one corrupted read of word 2
        mode = 1;
        push_run(32'hA5A55A5A, 32'hA5A45A5B, 32'hA5A75A58, 32'hA5A65A59);
        st_q.push_back('{p: 1'b0, ec: 16'h1, ffa: 32'h8, to: 1'b0, be: 1'b0});
        pulse_start(12'd4, 32'hA5A5_A5A5);
        wait_done(200);

        // bus error on the second write
        mode = 3;
        push_txn(1'b1, 32'h0, 32'h0000FFFF);
        push_txn(1'b1, 32'h4, 32'h0001FFFE);
        st_q.push_back('{p: 1'b0, ec: 16'h0, ffa: 32'h0, to: 1'b0, be: 1'b1});
        pulse_start(12'd4, 32'h0);
        wait_done(200);
        repeat (10) @(negedge clk);
        check("berr_no_more_txn", 74'(bus_q.size()), 74'(0));

        // slave never acks
        mode = 2;
        push_txn(1'b1, 32'h0, 32'h0000FFFF);
        st_q.push_back('{p: 1'b0, ec: 16'h0, ffa: 32'h0, to: 1'b1, be: 1'b0});
        pulse_start(12'd4, 32'h0);
        wait_done(600);
        check("timeout_stb_cycles", 74'(last_stb_len), 74'(255));

        // asynchronous reset in the middle of a read
        mode = 0;
        push_run(32'h0000FFFF, 32'h0001FFFE, 32'h0002FFFD, 32'h0003FFFC);
        st_q.push_back('{p: 1'b1, ec: 16'h0, ffa: 32'h0, to: 1'b0, be: 1'b0});
        pulse_start(12'd4, 32'h0);
        c = 0;
        while (!(wb.cyc && !wb.we) && c < 200) begin
            @(negedge clk);
            c++;
        end
        check("read_cycle_reached", 74'(wb.cyc && !wb.we), 74'(1));
        #2 rst = 1'b1;
        #1;
        check("async_rst_bus", 74'({wb.cyc, wb.stb}), 74'(0));
        check("async_rst_busy_done", 74'({busy, done}), 74'(0));
        bus_q.delete();
        st_q.delete();
        @(negedge clk);
        rst = 1'b0;
        repeat (20) @(negedge clk);
        check("post_rst_idle", 74'({busy, done, wb.cyc}), 74'(0));

        // full-depth run
        for (int i = 0; i < 2048; i++) begin
            logic [15:0] h;
            h = 16'(i);
            push_txn(1'b1, 32'(i * 4), {h, ~h});
        end
        for (int i = 0; i < 2048; i++) push_txn(1'b0, 32'(i * 4), 32'h0);
        st_q.push_back('{p: 1'b1, ec: 16'h0, ffa: 32'h0, to: 1'b0, be: 1'b0});
        a0 = n_ack;
        pulse_start(12'h800, 32'h0);
        wait_done(20000);
        check("full_ack_count", 74'(n_ack - a0), 74'(4096));
        check("full_last_adr", 74'(last_adr), 74'(32'h1FFC));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule

// File: doc/wb_mem_bist.md
WB_MEM_BIST -- requirements
Module: wb_mem_bist

Interface
REQ-001 The block SHALL have parameter mem_adr_width, default 11, giving the log2 word depth of the target memory.
REQ-002 The block SHALL have parameter BASE_ADR, default 32'h0000_0000, giving the byte address of test word 0 (4-byte aligned).
REQ-003 The block SHALL have parameter TIMEOUT, default 255, giving the maximum cycles to wait for ack per transaction.
REQ-004 Port wb_m.clk  input  1  the single clock; wb_m.rst  input  1  reset, asynchronous and active-high. Both are carried in the wshb_if.master port wb_m.
REQ-005 Port wb_m  wshb_if.master  --  Wishbone classic master, driving cyc, stb, we, adr[31:0], sel[3:0], dat_ms[31:0], cti, bte; sampling ack, err, dat_sm[31:0].
REQ-006 Port start  input  1  one-cycle request to launch a test.
REQ-007 Port len  input  mem_adr_width+1  number of words to test, latched at start.
REQ-008 Port seed  input  32  pattern seed, latched at start.
REQ-009 Port busy  output  1  high while a test runs.
REQ-010 Port done  output  1  high from test end until the next accepted start.
REQ-011 Port pass  output  1  valid while done; 1 = no mismatch, no bus error, no timeout.
REQ-012 Port err_count  output  16  saturating count of read mismatches.
REQ-013 Port first_fail_adr  output  32  byte address of the first mismatch.
REQ-014 Port timeout  output  1  sticky flag, set when a transaction exceeds TIMEOUT.
REQ-015 Port bus_err  output  1  sticky flag, set when the slave asserts err.

Function
REQ-016 States SHALL be IDLE, WRITE, READ and DONE; the FSM SHALL leave DONE only on start.
REQ-017 A start in IDLE or DONE SHALL latch len and seed, clear the status outputs, and enter WRITE; if len==0 it SHALL enter DONE directly, with pass=1 and no bus activity.
REQ-018 A start while busy SHALL be ignored.
REQ-019 Word i (0..len-1) SHALL use adr = BASE_ADR + 4*i and pattern(i) = {i[15:0], ~i[15:0]} XOR seed, where i is zero-extended to 16 bits.
REQ-020 WRITE SHALL issue len single writes in ascending i with we=1, sel=4'hF, dat_ms=pattern(i), cti=3'b000, bte=2'b00.
REQ-021 READ SHALL then issue len single reads in ascending i with we=0 and sel=4'hF.
REQ-022 Handshake: cyc and stb SHALL be asserted together, with adr, we, sel and dat_ms held stable until ack or err is sampled high at a rising edge.
REQ-023 After each ack or err, cyc and stb SHALL be low for exactly one cycle before the next transaction, giving a minimum of 2 cycles per word.
REQ-024 A read SHALL compare all 32 bits of dat_sm at the ack edge against pattern(i). On mismatch, err_count SHALL increment (saturating at 16'hFFFF), and first_fail_adr SHALL be captured only on the first mismatch. The test SHALL continue.
REQ-025 When err is sampled high, the block SHALL set bus_err, drop cyc and stb, and go to DONE with pass=0.
REQ-026 A per-transaction counter SHALL reset at each stb assertion. When it reaches TIMEOUT with no ack or err, the block SHALL set timeout, drop cyc and stb the next cycle, and go to DONE with pass=0.
REQ-027 If ack and err are sampled high together, err SHALL take priority.
REQ-028 The word index SHALL count 0..len-1 with no wrap; len = 2**mem_adr_width SHALL test the full memory.
REQ-029 On the cycle the last read's ack is sampled, the FSM SHALL enter DONE next cycle: busy=0, done=1, pass = (err_count==0 && !timeout && !bus_err).

Reset
REQ-030 Asserting wb_m.rst SHALL immediately force, without waiting for a clock: state IDLE; cyc, stb, we = 0; adr, dat_ms = 0; sel = 0; cti, bte = 0; busy, done, pass, timeout, bus_err = 0; err_count = 0; first_fail_adr = 0.
REQ-031 Reset during a transaction SHALL abandon the test; after deassertion, no bus activity SHALL occur until the next start.

Verification
REQ-032 With wb_bram (mem_adr_width=11), len=4, seed=0 -> writes to 0x0,0x4,0x8,0xC with data 32'h0000FFFF, 32'h0001FFFE, 32'h0002FFFD, 32'h0003FFFC; then 4 reads; done=1, pass=1, err_count=0.
REQ-033 With a slave model that flips dat_sm bit 0 on the read of word 2 (len=4, seed=32'hA5A5A5A5) -> err_count=1, first_fail_adr=32'h8, pass=0, and all 8 transactions complete.
REQ-034 With a slave that never acks -> stb high for exactly 255 cycles, then cyc and stb low, timeout=1, done=1, pass=0.
REQ-035 With a slave asserting err on the second write -> bus_err=1, no further transactions, pass=0; with len=0 -> done=1 and pass=1 one cycle after start, cyc never high.
REQ-036 Reset asserted mid-read with cyc=1 -> cyc, stb and busy are 0 before the next clock edge; start pulses while busy produce no relaunch and no counter change.
REQ-037 Full-depth run with len=2048 -> last address 0x1FFC, exactly 4096 acks, pass=1.
